// File: rtl/bus_arbiter_mux_if.sv
// rtl/bus_arbiter_mux_if.sv - handshake bundle between channel sources, arbiter and consumer
//
// Purpose: groups the N:1 arbiter's data/handshake signals into one port.
// Macro:   ARB_LOCK_EN adds the burst-ownership 'lock' signal.
// Signals:
//   in_data   [CHANNELS*WIDTH] channel i word at [i*WIDTH +: WIDTH]
//   in_valid  [CHANNELS]       channel i offers a word
//   in_ready  [CHANNELS]       channel i word accepted this cycle
//   rr_mode                    0 = fixed priority, 1 = round-robin
//   out_data  [WIDTH]          registered selected word
//   out_valid                  out_data holds an unconsumed word
//   out_ready                  consumer accepts out_data
//   out_sel   [SEL_W]          channel that sourced out_data
//   lock                       (ARB_LOCK_EN only) hold grant on out_sel
// Modports: master = sources/consumer side, slave = arbiter side.
interface bus_arbiter_mux_if #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      rr_mode;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_sel;
`ifdef ARB_LOCK_EN
    logic                      lock;

    modport master (
        output in_data, in_valid, rr_mode, out_ready, lock,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, rr_mode, out_ready, lock,
        output in_ready, out_data, out_valid, out_sel
    );
`else
    modport master (
        output in_data, in_valid, rr_mode, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, rr_mode, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
`endif
endinterface

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - N:1 arbitrated bus multiplexer with registered output
//
// Purpose: picks one valid channel per cycle (fixed priority or round-robin)
//          and holds its word in an output register until the consumer takes it.
// Macro:   ARB_LOCK_EN - adds 'lock' for burst ownership of the current out_sel.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active high
//   bus  - bus_arbiter_mux_if.slave (in_data/in_valid/in_ready, rr_mode,
//          out_data/out_valid/out_ready/out_sel, lock when ARB_LOCK_EN)
module bus_arbiter_mux #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_arbiter_mux_if.slave     bus
);

    generate
        if (CHANNELS < 2 || CHANNELS > 16 || SEL_W != $clog2(CHANNELS)) begin : g_param_check
            $error("bus_arbiter_mux: illegal CHANNELS/SEL_W combination");
        end
    endgenerate

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load_en;
    logic                w_locked;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_grant_data;
    logic [SEL_W-1:0]    w_next_ptr;
    logic [CHANNELS-1:0] w_in_ready;
    logic                w_xfer;

    // The register can take a new word when it is empty or being drained
    // this very cycle, which gives back-to-back transfers with no bubble.
    assign w_load_en = !r_out_valid | bus.out_ready;

`ifdef ARB_LOCK_EN
    // Lock only means something while a word from the owning channel is held.
    assign w_locked = bus.lock & r_out_valid;
`else
    assign w_locked = 1'b0;
`endif

    // Search starts at rr_ptr in round-robin mode and at 0 in fixed-priority
    // mode; the first valid channel found, with wrap, wins.
    always_comb begin
        int base;
        int idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        base        = bus.rr_mode ? int'(r_rr_ptr) : 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = base + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_grant_vld && bus.in_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = SEL_W'(idx);
            end
        end
        // Burst owner keeps the bus even when it has nothing to send.
        if (w_locked) begin
            w_grant_vld = bus.in_valid[r_out_sel];
            w_grant_idx = r_out_sel;
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i == int'(w_grant_idx)) begin
                w_grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_next_ptr = (int'(w_grant_idx) == CHANNELS - 1) ? '0 : w_grant_idx + 1'b1;

    assign w_xfer = w_load_en & w_grant_vld;

    // Reset gates in_ready combinationally so no handshake completes while rst=1.
    always_comb begin
        w_in_ready = '0;
        if (!rst && w_xfer) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_grant_data;
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                // Pointer only moves in round-robin mode and never within a locked burst.
                if (bus.rr_mode && !w_locked) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - self-checking bench for bus_arbiter_mux
module tb_bus_arbiter_mux;

    localparam int W = 9;
    localparam int C = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus();

    bus_arbiter_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;

    typedef struct {
        logic [3:0] valid;
        logic       rr;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [8:0] exp_data;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_locked();
`ifdef ARB_LOCK_EN
        return bus.lock && m_valid;
`else
        return 1'b0;
`endif
    endfunction

    // Winner = valid channel with smallest distance from the search origin.
    function automatic int ref_winner();
        int best = C;
        int win  = -1;
        int d;
        if (model_locked()) begin
            return bus.in_valid[m_sel] ? m_sel : -1;
        end
        for (int i = 0; i < C; i++) begin
            if (bus.in_valid[i]) begin
                d = bus.rr_mode ? (i - m_ptr + C) % C : i;
                if (d < best) begin
                    best = d;
                    win  = i;
                end
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] ref_ready();
        int  w  = ref_winner();
        logic le = !m_valid || bus.out_ready;
        if (rst || !le || w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_update();
        int   w  = ref_winner();
        logic le = !m_valid || bus.out_ready;
        logic lk = model_locked();
        if (rst) begin
            model_reset();
        end else if (le && w >= 0) begin
            m_data  = bus.in_data[w*W +: W];
            m_sel   = w;
            m_valid = 1'b1;
            if (bus.rr_mode && !lk) m_ptr = (w + 1) % C;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_in_ready"},  {28'd0, bus.in_ready}, {28'd0, ref_ready()});
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk({tag, "_out_data"},  {23'd0, bus.out_data}, {23'd0, m_data});
        chk({tag, "_out_sel"},   {30'd0, bus.out_sel}, 32'(m_sel));
    endtask

    task automatic set_data(input logic [8:0] d0, d1, d2, d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [8:0] d, input logic [1:0] s);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
        chk({tag, "_out_data"},  {23'd0, bus.out_data}, {23'd0, d});
        chk({tag, "_out_sel"},   {30'd0, bus.out_sel}, {30'd0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] r);
        chk({tag, "_in_ready"}, {28'd0, bus.in_ready}, {28'd0, r});
    endtask

    initial begin
        // valid, rr, ordy | in_ready, out_valid, out_data, out_sel (after edge)
        tbl[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};
        tbl[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};
        tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 9'h022, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 9'h033, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 9'h044, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};
        tbl[8]  = '{4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 9'h022, 2'd1};
        tbl[9]  = '{4'b1010, 1'b1, 1'b1, 4'b1000, 1'b1, 9'h044, 2'd3};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 9'h044, 2'd3};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 9'h044, 2'd3};
        tbl[12] = '{4'b0110, 1'b0, 1'b1, 4'b0010, 1'b1, 9'h022, 2'd1};
        tbl[13] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 1'b1, 9'h022, 2'd1};
        tbl[14] = '{4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 9'h022, 2'd1};
        tbl[15] = '{4'b0110, 1'b1, 1'b1, 4'b0100, 1'b1, 9'h033, 2'd2};
        tbl[16] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 9'h011, 2'd0};

        rst = 1'b1;
        bus.in_valid  = '0;
        bus.rr_mode   = 1'b0;
        bus.out_ready = 1'b0;
        set_data(9'h011, 9'h022, 9'h033, 9'h044);
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 9'h000, 2'd0);
        chk_rdy("reset", 4'b0000);
        rst = 1'b0;

        // Fixed priority, round-robin, sparse wrap, drain and stall
        for (int r = 0; r < 17; r++) begin
            bus.in_valid  = tbl[r].valid;
            bus.rr_mode   = tbl[r].rr;
            bus.out_ready = tbl[r].ordy;
            #1;
            chk_rdy($sformatf("tbl%0d", r), tbl[r].exp_rdy);
            tick();
            chk_out($sformatf("tbl%0d", r), tbl[r].exp_ov, tbl[r].exp_data, tbl[r].exp_sel);
        end

        // Backpressure: ch2 word 0x1FF held across 3 stalled cycles
        bus.in_valid = 4'b0000; bus.rr_mode = 1'b0; bus.out_ready = 1'b1;
        tick();
        chk_out("bp_empty", 1'b0, 9'h011, 2'd0);
        set_data(9'h011, 9'h022, 9'h1FF, 9'h044);
        bus.in_valid = 4'b0100; bus.out_ready = 1'b0;
        #1;
        chk_rdy("bp_load", 4'b0100);
        tick();
        chk_out("bp_load", 1'b1, 9'h1FF, 2'd2);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp_stall", 4'b0000);
            tick();
            chk_out("bp_stall", 1'b1, 9'h1FF, 2'd2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk_rdy("bp_release", 4'b0100);
        tick();
        chk_out("bp_release", 1'b1, 9'h1FF, 2'd2);
        bus.in_valid = 4'b0000;
        tick();
        chk_out("bp_drain", 1'b0, 9'h1FF, 2'd2);

        // Drain: single word from ch1 visible for exactly one cycle
        set_data(9'h011, 9'h0AB, 9'h033, 9'h044);
        bus.in_valid = 4'b0010;
        #1;
        chk_rdy("drain_load", 4'b0010);
        tick();
        chk_out("drain_load", 1'b1, 9'h0AB, 2'd1);
        bus.in_valid = 4'b0000;
        #1;
        chk_rdy("drain_idle", 4'b0000);
        tick();
        chk_out("drain_1", 1'b0, 9'h0AB, 2'd1);
        tick();
        chk_out("drain_2", 1'b0, 9'h0AB, 2'd1);

        // Reset mid-stream clears outputs without a clock edge
        set_data(9'h011, 9'h022, 9'h033, 9'h155);
        bus.in_valid = 4'b1000; bus.out_ready = 1'b0;
        tick();
        chk_out("pre_rst", 1'b1, 9'h155, 2'd3);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 9'h000, 2'd0);
        chk_rdy("async_rst", 4'b0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_data(9'h011, 9'h022, 9'h033, 9'h044);
        bus.rr_mode = 1'b1; bus.in_valid = 4'b1010;
        #1;
        chk_rdy("post_rst_rr", 4'b0010);
        tick();
        chk_out("post_rst_rr", 1'b1, 9'h022, 2'd1);

`ifdef ARB_LOCK_EN
        // Lock: ch1 owns the bus while lock=1, then rr resumes at ch3
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        bus.rr_mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 4'b1011;
        #1;
        chk_rdy("lk_first", 4'b0001);
        tick();
        chk_rdy("lk_win1", 4'b0010);
        tick();
        chk_out("lk_win1", 1'b1, 9'h022, 2'd1);
        bus.lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("lk_hold", 4'b0010);
            tick();
            chk_out("lk_hold", 1'b1, 9'h022, 2'd1);
        end
        bus.lock = 1'b0;
        #1;
        chk_rdy("lk_release", 4'b1000);
        tick();
        chk_out("lk_release", 1'b1, 9'h044, 2'd3);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 4'($urandom_range(0, 15));
            bus.in_data   = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
            if ($urandom_range(0, 7) == 0) bus.rr_mode = ~bus.rr_mode;
            bus.out_ready = ($urandom_range(0, 9) < 7);
`ifdef ARB_LOCK_EN
            bus.lock = ($urandom_range(0, 3) == 0);
`endif
            #1;
            check_model("rand");
            tick();
        end
        check_model("rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised N:1 data-bus multiplexer with arbitration and a registered output, for CPU datapath buses (default 9-bit words, carry included).
- Generalises the 2:1 bus select to CHANNELS sources, each with a valid/ready handshake.
- Selects one requester per cycle by fixed priority or round-robin.
- Holds the selected word in an output register until the consumer accepts it.

Parameters:
- WIDTH, 9, data word width in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, width of the channel index; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  channel i offers a word.
- in_ready  output  CHANNELS  channel i word accepted this cycle.
- rr_mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- out_sel  output  SEL_W  index of the channel that sourced out_data.

Behaviour:
- Reset (async, rst=1) forces: out_valid=0, out_data=0, out_sel=0, in_ready=0, round-robin pointer rr_ptr=0.
- Reset asserted mid-transfer discards the held word; no handshake completes in a cycle where rst=1.
- load_en = !out_valid | out_ready. The output register may load only when load_en=1.
- Arbitration is combinational and happens every cycle:
  - rr_mode=0: the lowest-index channel with in_valid wins.
  - rr_mode=1: the first valid channel at or after rr_ptr wins, searching upward and wrapping from CHANNELS-1 to 0.
- in_ready[g] = load_en & in_valid[g] for the winner g. All other in_ready bits are 0. At most one in_ready bit is high.
- On a transfer (in_valid[g] & in_ready[g]), at the next edge:
  - out_data <= word from channel g.
  - out_sel <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod CHANNELS.
- If no channel is valid and out_ready=1 with out_valid=1, then out_valid <= 0. out_data and out_sel keep their old values.
- While out_valid=1 and out_ready=0: out_data and out_sel are stable and no input is accepted.
- Latency: input accept to out_valid is 1 cycle. Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous drain and load: the consumer takes the old word and the new word loads on the same edge, with no bubble.
- rr_ptr advances only on a transfer. It is not updated while rr_mode=0.
- Switching rr_mode mid-stream takes effect in the same cycle; rr_ptr keeps its value.
- Words are passed through unchanged. No truncation, no arithmetic.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While lock=1 and out_valid=1, arbitration is restricted to channel out_sel. Other channels are never granted, even if that channel is idle (burst ownership).
  - rr_ptr does not advance during the locked burst. It advances to out_sel+1 on the first transfer after lock falls.
  - lock=1 with out_valid=0 has no effect.
- Not defined:
  - No `lock` port.
  - Arbitration behaves exactly as described in Behaviour.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately, without waiting for a clock edge.
- Fixed priority: rr_mode=0, all four valid, data 0x011/0x022/0x033/0x044, out_ready=1 -> outputs 0x011, sel 0, every cycle. Only in_ready[0] pulses.
- Round-robin: rr_mode=1, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 for 3 cycles with ch2 valid (0x1FF) -> word latched once; out_data=0x1FF stable; in_ready=0 throughout; one transfer when out_ready returns to 1.
- Drain: single word from ch1, no further valid, out_ready=1 -> out_valid high for exactly 1 cycle, then 0.
- ARB_LOCK_EN: rr_mode=1, lock=1 after ch1 wins, ch0/ch1/ch3 valid -> only ch1 granted while lock=1. After lock falls, next grant is ch3.
